lsu_mem_unit: RTL and testbench
===============================

LSU_MEM_UNIT -- requirements
Module: lsu_mem_unit

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 rdy  in  1  global enable; when low, all state, counters and outputs hold.
REQ-004 LSB_input_valid  in  1  LSBuffer issues one load/store this cycle.
REQ-005 LSB_OP_ID  in  `OpIdBus  one of OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW (defines.v).
REQ-006 LSB_reg_rs1, LSB_reg_rs2, LSB_imm  in  32 each  base, store data, sign-extended offset.
REQ-007 LSB_ROB_id  in  `ROBIDBus  ROB tag of issued op.
REQ-008 LSB_is_busy  out  1  unit cannot accept an issue this cycle.
REQ-009 MC_valid, MC_wr  out  1 each  byte request to memory controller; MC_wr=1 for write.
REQ-010 MC_addr  out  32; MC_wdata  out  8  request byte address and write byte.
REQ-011 MC_done  in  1; MC_rdata  in  8  request completion and read byte.
REQ-012 ROB_commit_valid  in  1; ROB_commit_ROB_id  in  `ROBIDBus  ROB store commit (used only with LSU_STORE_COMMIT_EN).
REQ-013 ROB_flush  in  1  misprediction clear.
REQ-014 ROB_output_valid  out  1; ROB_output_ROB_id  out  `ROBIDBus; ROB_output_value  out  32  completion broadcast.

Function
REQ-015 States IDLE, WAIT_COMMIT, ACCESS, DONE; only IDLE accepts issues.
REQ-016 LSB_is_busy SHALL be 1 in every state except IDLE.
REQ-017 In IDLE with LSB_input_valid=1: latch op, rob_id, rs2, addr=rs1+imm (mod 2^32), byte count n (1/2/4 for B/H/W), byte index k=0.
REQ-018 Issue in non-IDLE state SHALL be ignored without state change.
REQ-019 From IDLE: loads, and stores without commit gating, go to ACCESS; gated stores go to WAIT_COMMIT.
REQ-020 ACCESS: MC_valid=1, MC_addr=addr+k, MC_wr=1 for stores; MC_wdata=byte k of rs2 (little-endian); request fields held stable until MC_done.
REQ-021 On MC_done: load stores MC_rdata into result byte k; k increments; when k reaches n-1 on done, go to DONE; MC_valid deasserts the following cycle.
REQ-022 DONE lasts one cycle: ROB_output_valid=1, rob_id, value; then IDLE.
REQ-023 Load value: LB/LH sign-extend, LBU/LHU zero-extend, LW as assembled; store value = 0.
REQ-024 Misaligned addresses SHALL be handled byte-wise with no fault.
REQ-025 Minimum latency: issue at cycle T, first MC_valid at T+1, ROB_output_valid at T+1+n+1 with MC_done asserted on each request cycle.
REQ-026 ROB_flush in IDLE, WAIT_COMMIT, or ACCESS of a load: abort to IDLE next cycle, drop MC_valid, no broadcast.
REQ-027 ROB_flush during ACCESS of a store SHALL NOT abort; the store completes and its broadcast is suppressed.
REQ-028 ROB_flush in DONE SHALL suppress ROB_output_valid.
REQ-029 ROB_flush coincident with an issue in IDLE: issue ignored.

Reset
REQ-030 rst low: state=IDLE, k=0, LSB_is_busy=0, MC_valid=0, MC_wr=0, MC_addr=0, MC_wdata=0, ROB_output_valid=0, ROB_output_ROB_id=0, ROB_output_value=0, immediately and independent of clk.
REQ-031 Reset mid-ACCESS abandons the transfer; no broadcast follows.

Configuration
REQ-032 Macro LSU_STORE_COMMIT_EN defined: stores wait in WAIT_COMMIT until ROB_commit_valid=1 with ROB_commit_ROB_id equal to the latched tag, then go to ACCESS next cycle; a flush in WAIT_COMMIT discards the store.
REQ-033 LSU_STORE_COMMIT_EN undefined: WAIT_COMMIT is unreachable, ROB_commit inputs are ignored, and stores go directly to ACCESS.

Verification
REQ-034 LW, rs1=0x1000, imm=-4, MC_rdata 0x78,0x56,0x34,0x12 -> addresses 0xFFC..0xFFF, value 0x12345678, tag echoed.
REQ-035 LB then LBU at 0x20 with byte 0x80 -> values 0xFFFFFF80 and 0x00000080.
REQ-036 SH, rs2=0xAABBCCDD, addr 0x3 -> writes 0xDD@0x3, 0xCC@0x4, then broadcast value 0.
REQ-037 LSU_STORE_COMMIT_EN, SW tag 5: no MC_valid until commit tag 5; commit tag 4 has no effect.
REQ-038 ROB_flush during second byte of LH -> MC_valid drops next cycle, no broadcast, LSB_is_busy=0.
REQ-039 rst low mid-LW and rdy=0 for 3 cycles mid-ACCESS -> outputs reset immediately; stall holds MC_addr and k unchanged.

Source files
------------

// File: rtl/lsu_mem_unit.sv
// lsu_mem_unit: byte-serial load/store unit between the LSBuffer, the memory
// controller and the ROB. Each access is split into 1, 2 or 4 byte requests.
// Define LSU_STORE_COMMIT_EN to make stores wait for their ROB commit before
// touching memory. By default stores go to memory as soon as they are issued.

package lsu_mem_unit_pkg;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned OP_ID_W  = 4;
  localparam int unsigned ROB_ID_W = 4;

  localparam logic [OP_ID_W-1:0] OP_LB  = 4'd0;
  localparam logic [OP_ID_W-1:0] OP_LH  = 4'd1;
  localparam logic [OP_ID_W-1:0] OP_LW  = 4'd2;
  localparam logic [OP_ID_W-1:0] OP_LBU = 4'd3;
  localparam logic [OP_ID_W-1:0] OP_LHU = 4'd4;
  localparam logic [OP_ID_W-1:0] OP_SB  = 4'd5;
  localparam logic [OP_ID_W-1:0] OP_SH  = 4'd6;
  localparam logic [OP_ID_W-1:0] OP_SW  = 4'd7;
endpackage

module lsu_mem_unit
  import lsu_mem_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                LSB_input_valid,
  input  logic [OP_ID_W-1:0]  LSB_OP_ID,
  input  logic [XLEN-1:0]     LSB_reg_rs1,
  input  logic [XLEN-1:0]     LSB_reg_rs2,
  input  logic [XLEN-1:0]     LSB_imm,
  input  logic [ROB_ID_W-1:0] LSB_ROB_id,
  output logic                LSB_is_busy,
  output logic                MC_valid,
  output logic                MC_wr,
  output logic [XLEN-1:0]     MC_addr,
  output logic [7:0]          MC_wdata,
  input  logic                MC_done,
  input  logic [7:0]          MC_rdata,
  input  logic                ROB_commit_valid,
  input  logic [ROB_ID_W-1:0] ROB_commit_ROB_id,
  input  logic                ROB_flush,
  output logic                ROB_output_valid,
  output logic [ROB_ID_W-1:0] ROB_output_ROB_id,
  output logic [XLEN-1:0]     ROB_output_value
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_COMMIT = 2'd1,
    S_ACCESS      = 2'd2,
    S_DONE        = 2'd3
  } state_e;

  state_e                state_q;
  logic [OP_ID_W-1:0]    op_q;
  logic [ROB_ID_W-1:0]   rob_id_q;
  logic [XLEN-1:0]       rs2_q;
  logic [XLEN-1:0]       addr_q;
  logic [XLEN-1:0]       res_q;
  logic [1:0]            k_q;
  logic [1:0]            nlast_q;
  logic                  flushed_q;
  logic                  busy_q;
  logic                  mc_valid_q;
  logic                  mc_wr_q;
  logic [XLEN-1:0]       mc_addr_q;
  logic [7:0]            mc_wdata_q;
  logic                  out_valid_q;
  logic [ROB_ID_W-1:0]   out_id_q;
  logic [XLEN-1:0]       out_value_q;

  logic [XLEN-1:0]       addr_d;
  logic [1:0]            k_d;
  logic [XLEN-1:0]       mc_addr_d;
  logic [7:0]            mc_wdata_d;
  logic [XLEN-1:0]       out_value_d;
  logic                  issue_store_c;
  logic [1:0]            issue_nlast_c;
  logic                  issue_gated_c;
  logic                  commit_hit_c;

  function automatic logic is_store_op(input logic [OP_ID_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Index of the last byte of the access (0, 1 or 3).
  function automatic logic [1:0] last_byte(input logic [OP_ID_W-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 2'd0;
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      default:              return 2'd3;
    endcase
  endfunction

  // Loaded value with sign/zero extension; stores broadcast zero.
  function automatic logic [XLEN-1:0] load_value(input logic [OP_ID_W-1:0] op,
                                                 input logic [XLEN-1:0]    r);
    case (op)
      OP_LB:   return {{24{r[7]}}, r[7:0]};
      OP_LH:   return {{16{r[15]}}, r[15:0]};
      OP_LBU:  return {24'd0, r[7:0]};
      OP_LHU:  return {16'd0, r[15:0]};
      OP_LW:   return r;
      default: return '0;
    endcase
  endfunction

`ifdef LSU_STORE_COMMIT_EN
  assign issue_gated_c = is_store_op(LSB_OP_ID);
  assign commit_hit_c  = ROB_commit_valid && (ROB_commit_ROB_id == rob_id_q);
`else
  // Commit port is not used when stores are not held for commit.
  logic unused_commit_c;
  assign unused_commit_c = ^{ROB_commit_valid, ROB_commit_ROB_id};
  assign issue_gated_c   = 1'b0;
  assign commit_hit_c    = 1'b0;
`endif

  // Effective address, next byte request and completion value.
  always_comb begin
    addr_d        = LSB_reg_rs1 + LSB_imm;
    issue_store_c = is_store_op(LSB_OP_ID);
    issue_nlast_c = last_byte(LSB_OP_ID);
    k_d           = k_q + 2'd1;
    mc_addr_d     = addr_q + 32'(k_d);
    mc_wdata_d    = rs2_q[{k_d, 3'b000} +: 8];
    out_value_d   = load_value(op_q, res_q);
  end

  // Control FSM, byte sequencing and registered outputs; everything holds when rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      rob_id_q    <= '0;
      rs2_q       <= '0;
      addr_q      <= '0;
      res_q       <= '0;
      k_q         <= '0;
      nlast_q     <= '0;
      flushed_q   <= 1'b0;
      busy_q      <= 1'b0;
      mc_valid_q  <= 1'b0;
      mc_wr_q     <= 1'b0;
      mc_addr_q   <= '0;
      mc_wdata_q  <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_value_q <= '0;
    end else if (rdy) begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (LSB_input_valid && !ROB_flush) begin
            op_q       <= LSB_OP_ID;
            rob_id_q   <= LSB_ROB_id;
            rs2_q      <= LSB_reg_rs2;
            addr_q     <= addr_d;
            nlast_q    <= issue_nlast_c;
            k_q        <= 2'd0;
            res_q      <= '0;
            flushed_q  <= 1'b0;
            busy_q     <= 1'b1;
            mc_addr_q  <= addr_d;
            mc_wr_q    <= issue_store_c;
            mc_wdata_q <= LSB_reg_rs2[7:0];
            mc_valid_q <= !issue_gated_c;
            state_q    <= issue_gated_c ? S_WAIT_COMMIT : S_ACCESS;
          end
        end
        S_WAIT_COMMIT: begin
          if (ROB_flush) begin
            busy_q  <= 1'b0;
            mc_wr_q <= 1'b0;
            state_q <= S_IDLE;
          end else if (commit_hit_c) begin
            mc_valid_q <= 1'b1;
            state_q    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (ROB_flush && !is_store_op(op_q)) begin
            // Loads are speculative and can be dropped mid-transfer.
            mc_valid_q <= 1'b0;
            mc_wr_q    <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            // A store already in flight finishes but must not broadcast.
            if (ROB_flush) flushed_q <= 1'b1;
            if (MC_done) begin
              if (!is_store_op(op_q)) res_q[{k_q, 3'b000} +: 8] <= MC_rdata;
              if (k_q == nlast_q) begin
                mc_valid_q <= 1'b0;
                mc_wr_q    <= 1'b0;
                state_q    <= S_DONE;
              end else begin
                k_q        <= k_d;
                mc_addr_q  <= mc_addr_d;
                mc_wdata_q <= mc_wdata_d;
              end
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (!ROB_flush && !flushed_q) begin
            out_valid_q <= 1'b1;
            out_id_q    <= rob_id_q;
            out_value_q <= out_value_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign LSB_is_busy       = busy_q;
  assign MC_valid          = mc_valid_q;
  assign MC_wr             = mc_wr_q;
  assign MC_addr           = mc_addr_q;
  assign MC_wdata          = mc_wdata_q;
  assign ROB_output_valid  = out_valid_q;
  assign ROB_output_ROB_id = out_id_q;
  assign ROB_output_value  = out_value_q;

endmodule

// File: tb/tb_lsu_mem_unit.sv
// Scoreboard bench for lsu_mem_unit: stimulus pushes expected memory requests
// and ROB broadcasts; a negedge monitor pops and compares them.
module tb_lsu_mem_unit;
  import lsu_mem_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        LSB_input_valid;
  logic [3:0]  LSB_OP_ID;
  logic [31:0] LSB_reg_rs1;
  logic [31:0] LSB_reg_rs2;
  logic [31:0] LSB_imm;
  logic [3:0]  LSB_ROB_id;
  logic        LSB_is_busy;
  logic        MC_valid;
  logic        MC_wr;
  logic [31:0] MC_addr;
  logic [7:0]  MC_wdata;
  logic        MC_done;
  logic [7:0]  MC_rdata;
  logic        ROB_commit_valid;
  logic [3:0]  ROB_commit_ROB_id;
  logic        ROB_flush;
  logic        ROB_output_valid;
  logic [3:0]  ROB_output_ROB_id;
  logic [31:0] ROB_output_value;

  logic        done_en;
  logic [7:0]  mem [0:255];

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  wdata;
  } mc_exp_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] value;
  } rob_exp_t;

  mc_exp_t  mc_q[$];
  rob_exp_t rob_q[$];
  mc_exp_t  me;
  rob_exp_t re;
  int       n_cmp;
  int       n_err;

  lsu_mem_unit dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .LSB_input_valid   (LSB_input_valid),
    .LSB_OP_ID         (LSB_OP_ID),
    .LSB_reg_rs1       (LSB_reg_rs1),
    .LSB_reg_rs2       (LSB_reg_rs2),
    .LSB_imm           (LSB_imm),
    .LSB_ROB_id        (LSB_ROB_id),
    .LSB_is_busy       (LSB_is_busy),
    .MC_valid          (MC_valid),
    .MC_wr             (MC_wr),
    .MC_addr           (MC_addr),
    .MC_wdata          (MC_wdata),
    .MC_done           (MC_done),
    .MC_rdata          (MC_rdata),
    .ROB_commit_valid  (ROB_commit_valid),
    .ROB_commit_ROB_id (ROB_commit_ROB_id),
    .ROB_flush         (ROB_flush),
    .ROB_output_valid  (ROB_output_valid),
    .ROB_output_ROB_id (ROB_output_ROB_id),
    .ROB_output_value  (ROB_output_value)
  );

  // Memory controller model: answers every request in the same cycle when enabled.
  assign MC_done  = MC_valid & done_en;
  assign MC_rdata = mem[MC_addr[7:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a completed request or a broadcast is matched against the queues.
  always @(negedge clk) begin
    if (rst && rdy) begin
      if (MC_valid && MC_done) begin
        if (mc_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL mc_unexpected: got request at 0x%08h, expected none", MC_addr);
        end else begin
          me = mc_q.pop_front();
          chk("mc_addr", MC_addr, me.addr);
          chk("mc_wr", 32'(MC_wr), 32'(me.wr));
          if (me.wr) chk("mc_wdata", 32'(MC_wdata), 32'(me.wdata));
        end
      end
      if (ROB_output_valid) begin
        if (rob_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rob_unexpected: got tag %0d value 0x%08h, expected none",
                   ROB_output_ROB_id, ROB_output_value);
        end else begin
          re = rob_q.pop_front();
          chk("rob_id", 32'(ROB_output_ROB_id), 32'(re.id));
          chk("rob_value", ROB_output_value, re.value);
        end
      end
    end
  end

  task automatic exp_load(input logic [31:0] addr, input int n, input logic [3:0] id,
                          input logic [31:0] value);
    mc_exp_t m;
    rob_exp_t r;
    for (int i = 0; i < n; i++) begin
      m.addr = addr + 32'(i); m.wr = 1'b0; m.wdata = 8'h00;
      mc_q.push_back(m);
    end
    r.id = id; r.value = value;
    rob_q.push_back(r);
  endtask

  task automatic exp_store(input logic [31:0] addr, input int n, input logic [31:0] data,
                           input logic [3:0] id, input bit bcast);
    mc_exp_t m;
    rob_exp_t r;
    for (int i = 0; i < n; i++) begin
      m.addr = addr + 32'(i); m.wr = 1'b1; m.wdata = data[8*i +: 8];
      mc_q.push_back(m);
    end
    if (bcast) begin
      r.id = id; r.value = 32'h0;
      rob_q.push_back(r);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [3:0] id);
    LSB_input_valid = 1'b1;
    LSB_OP_ID       = op;
    LSB_reg_rs1     = rs1;
    LSB_reg_rs2     = rs2;
    LSB_imm         = imm;
    LSB_ROB_id      = id;
    @(posedge clk); #1;
    LSB_input_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [3:0] id);
    ROB_commit_valid  = 1'b1;
    ROB_commit_ROB_id = id;
    @(posedge clk); #1;
    ROB_commit_valid  = 1'b0;
  endtask

  task automatic store_commit(input logic [3:0] id);
`ifdef LSU_STORE_COMMIT_EN
    do_commit(id);
`else
    if (id == 4'hF) $display("note: commit tag 15 unused");
`endif
  endtask

  // Counts clock edges from the issue edge to the broadcast.
  task automatic wait_bcast(input int n, input string name);
    int lat;
    lat = 0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (ROB_output_valid) begin
        lat = e;
        break;
      end
    end
    chk(name, 32'(lat), 32'(n + 1));
  endtask

  task automatic run_to_idle(input string name);
    bit idle;
    idle = 1'b0;
    for (int e = 0; e < 60; e++) begin
      @(posedge clk); #1;
      if (!LSB_is_busy) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got busy after 60 cycles, expected idle", name);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b0; rdy = 1'b1; done_en = 1'b1;
    LSB_input_valid = 1'b0; LSB_OP_ID = OP_LB; LSB_reg_rs1 = '0; LSB_reg_rs2 = '0;
    LSB_imm = '0; LSB_ROB_id = '0; ROB_commit_valid = 1'b0; ROB_commit_ROB_id = '0;
    ROB_flush = 1'b0;

    // Reset values, checked before any clock edge
    #3;
    chk("rst_busy", 32'(LSB_is_busy), 32'h0);
    chk("rst_mc_valid", 32'(MC_valid), 32'h0);
    chk("rst_mc_wr", 32'(MC_wr), 32'h0);
    chk("rst_mc_addr", MC_addr, 32'h0);
    chk("rst_mc_wdata", 32'(MC_wdata), 32'h0);
    chk("rst_out_valid", 32'(ROB_output_valid), 32'h0);
    chk("rst_out_id", 32'(ROB_output_ROB_id), 32'h0);
    chk("rst_out_value", ROB_output_value, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // LW with negative offset
    mem[8'hFC] = 8'h78; mem[8'hFD] = 8'h56; mem[8'hFE] = 8'h34; mem[8'hFF] = 8'h12;
    exp_load(32'h0000_0FFC, 4, 4'd3, 32'h1234_5678);
    issue(OP_LW, 32'h0000_1000, 32'h0, 32'hFFFF_FFFC, 4'd3);
    wait_bcast(4, "lw_latency");
    run_to_idle("lw");

    // LB / LBU of 0x80
    mem[8'h20] = 8'h80;
    exp_load(32'h20, 1, 4'd1, 32'hFFFF_FF80);
    issue(OP_LB, 32'h10, 32'h0, 32'h10, 4'd1);
    wait_bcast(1, "lb_latency");
    run_to_idle("lb");
    exp_load(32'h20, 1, 4'd2, 32'h0000_0080);
    issue(OP_LBU, 32'h20, 32'h0, 32'h0, 4'd2);
    run_to_idle("lbu");

    // LH / LHU of 0x8234
    mem[8'h30] = 8'h34; mem[8'h31] = 8'h82;
    exp_load(32'h30, 2, 4'd4, 32'hFFFF_8234);
    issue(OP_LH, 32'h30, 32'h0, 32'h0, 4'd4);
    wait_bcast(2, "lh_latency");
    run_to_idle("lh");
    exp_load(32'h30, 2, 4'd6, 32'h0000_8234);
    issue(OP_LHU, 32'h31, 32'h0, 32'hFFFF_FFFF, 4'd6);
    run_to_idle("lhu");

    // Misaligned SH
    exp_store(32'h3, 2, 32'hAABB_CCDD, 4'd8, 1'b1);
    issue(OP_SH, 32'h0, 32'hAABB_CCDD, 32'h3, 4'd8);
    store_commit(4'd8);
    run_to_idle("sh");

    // Flush during store ACCESS, with an ignored issue while busy
    done_en = 1'b0;
    exp_store(32'h60, 1, 32'h0000_005A, 4'd2, 1'b0);
    issue(OP_SB, 32'h60, 32'h0000_005A, 32'h0, 4'd2);
    store_commit(4'd2);
    ROB_flush = 1'b1;
    LSB_input_valid = 1'b1; LSB_OP_ID = OP_LW; LSB_reg_rs1 = 32'h90; LSB_ROB_id = 4'd12;
    @(posedge clk); #1;
    ROB_flush = 1'b0;
    LSB_input_valid = 1'b0;
    chk("sb_flush_busy", 32'(LSB_is_busy), 32'h1);
    chk("sb_flush_valid", 32'(MC_valid), 32'h1);
    chk("sb_flush_addr", MC_addr, 32'h60);
    done_en = 1'b1;
    run_to_idle("sb_flush");

    // Flush during the second byte of LH
    mem[8'h50] = 8'h01;
    me.addr = 32'h50; me.wr = 1'b0; me.wdata = 8'h00;
    mc_q.push_back(me);
    issue(OP_LH, 32'h50, 32'h0, 32'h0, 4'd10);
    @(posedge clk); #1;
    done_en = 1'b0;
    ROB_flush = 1'b1;
    @(posedge clk); #1;
    ROB_flush = 1'b0;
    chk("lh_flush_valid", 32'(MC_valid), 32'h0);
    chk("lh_flush_busy", 32'(LSB_is_busy), 32'h0);
    repeat (4) @(posedge clk);
    #1 done_en = 1'b1;

    // Flush coincident with an issue in IDLE
    ROB_flush = 1'b1;
    issue(OP_LW, 32'h0, 32'h0, 32'h40, 4'd11);
    ROB_flush = 1'b0;
    chk("flush_issue_busy", 32'(LSB_is_busy), 32'h0);
    chk("flush_issue_valid", 32'(MC_valid), 32'h0);

    // rdy stall in the middle of LW
    mem[8'h40] = 8'h11; mem[8'h41] = 8'h22; mem[8'h42] = 8'h33; mem[8'h43] = 8'h44;
    exp_load(32'h40, 4, 4'd7, 32'h4433_2211);
    issue(OP_LW, 32'h40, 32'h0, 32'h0, 4'd7);
    @(posedge clk); #1;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_addr", MC_addr, 32'h41);
      chk("stall_valid", 32'(MC_valid), 32'h1);
    end
    rdy = 1'b1;
    run_to_idle("stall_lw");

    // Asynchronous reset mid-LW
    done_en = 1'b0;
    issue(OP_LW, 32'h80, 32'h0, 32'h0, 4'd9);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(LSB_is_busy), 32'h0);
    chk("arst_mc_valid", 32'(MC_valid), 32'h0);
    chk("arst_mc_addr", MC_addr, 32'h0);
    chk("arst_out_id", 32'(ROB_output_ROB_id), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    done_en = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("arst_idle", 32'(LSB_is_busy), 32'h0);

`ifdef LSU_STORE_COMMIT_EN
    // Store waits for its own commit tag
    exp_store(32'h70, 4, 32'h1122_3344, 4'd5, 1'b1);
    issue(OP_SW, 32'h70, 32'h1122_3344, 32'h0, 4'd5);
    repeat (2) @(posedge clk);
    #1 chk("commit_wait_valid", 32'(MC_valid), 32'h0);
    do_commit(4'd4);
    @(posedge clk); #1;
    chk("commit_wrong_tag", 32'(MC_valid), 32'h0);
    do_commit(4'd5);
    chk("commit_hit_valid", 32'(MC_valid), 32'h1);
    run_to_idle("sw_commit");
`else
    // Store goes straight to memory; commit inputs have no effect
    ROB_commit_valid = 1'b1; ROB_commit_ROB_id = 4'd4;
    exp_store(32'h70, 4, 32'h1122_3344, 4'd5, 1'b1);
    issue(OP_SW, 32'h70, 32'h1122_3344, 32'h0, 4'd5);
    chk("sw_direct_valid", 32'(MC_valid), 32'h1);
    ROB_commit_valid = 1'b0;
    run_to_idle("sw_direct");
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("mc_queue_empty", 32'(mc_q.size()), 32'h0);
    chk("rob_queue_empty", 32'(rob_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
